// File: rtl/fact_pkg.sv
// fact_pkg -- shared sizes and FSM encoding for the factorial scheduler.
//   NW : default operand width (N ranges 0 .. 2**NW-1)
//   ZW : default result width
//   state_e : scheduler FSM states
package fact_pkg;

    localparam int NW = 4;
    localparam int ZW = 48;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin arbiter, purely combinational.
// Ports:
//   req0, req1 : request levels
//   last       : index of the requester served most recently
//   grant[1:0] : one-hot grant (all zero when nobody requests)
// A lone requester always wins; on a tie the requester that was not
// served last wins.
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] grant
);

    assign grant[0] = req0 & (~req1 | last);
    assign grant[1] = req1 & (~req0 | ~last);

endmodule

// File: rtl/fact_sched.sv
// fact_sched -- two-requester factorial engine with round-robin arbitration.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   req0/n0        : requester 0 request level and operand
//   req1/n1        : requester 1 request level and operand
//   gnt0/gnt1      : one-cycle accept pulses (registered)
//   busy           : high while a job is multiplying
//   done           : one-cycle pulse, Z and owner valid
//   Z              : last result, held until the next done
//   owner          : requester index of the job that produced Z
// Jobs run one multiply per cycle on a single shared ZW x (NW+1)
// multiplier; the result is truncated to ZW bits.
module fact_sched #(
    parameter int NW = fact_pkg::NW,
    parameter int ZW = fact_pkg::ZW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [NW-1:0] n0,
    input  logic          req1,
    input  logic [NW-1:0] n1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          busy,
    output logic          done,
    output logic [ZW-1:0] Z,
    output logic          owner
);

    fact_pkg::state_e state;

    // cnt is one bit wider than nreg so it can reach 2**NW without wrapping
    logic [NW:0]   cnt;
    logic [NW-1:0] nreg;
    logic [ZW-1:0] acc;
    logic [ZW-1:0] prod;
    logic          last;
    logic [1:0]    grant;

    rr_arb2 u_arb (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .grant (grant)
    );

    assign prod = acc * ZW'(cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= fact_pkg::IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Z     <= '0;
            owner <= 1'b0;
            last  <= 1'b1;      // pretend requester 1 went last so 0 wins first tie
            acc   <= ZW'(1);
            cnt   <= (NW+1)'(2);
            nreg  <= '0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                fact_pkg::IDLE: begin
                    if (grant != 2'b00) begin
                        gnt0  <= grant[0];
                        gnt1  <= grant[1];
                        nreg  <= grant[0] ? n0 : n1;
                        acc   <= ZW'(1);
                        cnt   <= (NW+1)'(2);
                        owner <= grant[1];
                        last  <= grant[1];
                        busy  <= 1'b1;
                        state <= fact_pkg::MUL;
                    end
                end
                fact_pkg::MUL: begin
                    if (cnt <= {1'b0, nreg}) begin
                        acc <= prod;
                        cnt <= cnt + 1'b1;
                    end else begin
                        Z     <= acc;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= fact_pkg::IDLE;
                    end
                end
                default: state <= fact_pkg::IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fact_sched.sv
// tb_fact_sched -- directed self-checking bench for fact_sched.
module tb_fact_sched;

    localparam int NW = 4;
    localparam int ZW = 48;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1;
    logic [NW-1:0] n0, n1;
    logic          gnt0, gnt1, busy, done, owner;
    logic [ZW-1:0] Z;

    int checks = 0;
    int errors = 0;

    fact_sched #(.NW(NW), .ZW(ZW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .n0    (n0),
        .req1  (req1),
        .n1    (n1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .done  (done),
        .Z     (Z),
        .owner (owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One edge with requests set up beforehand; check which grant pulses.
    task automatic accept(input string tag, input logic eg0, input logic eg1, input logic drop);
        tick();
        chk({tag, " gnt0"}, 64'(gnt0), 64'(eg0));
        chk({tag, " gnt1"}, 64'(gnt1), 64'(eg1));
        chk({tag, " busy"}, 64'(busy), 64'd1);
        if (drop) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
    endtask

    // Count edges from the accept edge until done; bounded.
    task automatic wait_done(input string tag, input int ecyc, input logic [63:0] ez, input logic eown);
        int cyc;
        cyc = 0;
        do begin
            tick();
            cyc++;
            if (cyc == 1) chk({tag, " gnt pulse width"}, 64'(gnt0 | gnt1), 64'd0);
        end while (done !== 1'b1 && cyc < 40);
        chk({tag, " done seen"}, 64'(done), 64'd1);
        chk({tag, " latency"}, 64'(cyc), 64'(ecyc));
        chk({tag, " Z"}, 64'(Z), ez);
        chk({tag, " owner"}, 64'(owner), 64'(eown));
        chk({tag, " busy off"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; n0 = '0; n1 = '0;
        repeat (3) tick();
        chk("rst gnt0", 64'(gnt0), 64'd0);
        chk("rst gnt1", 64'(gnt1), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst Z", 64'(Z), 64'd0);
        chk("rst owner", 64'(owner), 64'd0);

        // both requesting out of reset: 0 first, then alternate
        req0 = 1'b1; req1 = 1'b1; n0 = 4'd3; n1 = 4'd4;
        rst_n = 1'b1;
        accept("rr a", 1'b1, 1'b0, 1'b0);
        wait_done("rr a", 3, 64'd6, 1'b0);
        accept("rr b", 1'b0, 1'b1, 1'b0);
        wait_done("rr b", 4, 64'd24, 1'b1);
        accept("rr c", 1'b1, 1'b0, 1'b1);
        wait_done("rr c", 3, 64'd6, 1'b0);
        tick();
        chk("idle done pulse", 64'(done), 64'd0);
        chk("idle no gnt", 64'(gnt0 | gnt1), 64'd0);
        chk("idle Z held", 64'(Z), 64'd6);

        // 5! from requester 0
        req0 = 1'b1; n0 = 4'd5;
        accept("n5", 1'b1, 1'b0, 1'b1);
        wait_done("n5", 5, 64'd120, 1'b0);

        // 0! and 1! from requester 1
        req1 = 1'b1; n1 = 4'd0;
        accept("n1=0", 1'b0, 1'b1, 1'b1);
        wait_done("n1=0", 1, 64'd1, 1'b1);
        req1 = 1'b1; n1 = 4'd1;
        accept("n1=1", 1'b0, 1'b1, 1'b1);
        wait_done("n1=1", 1, 64'd1, 1'b1);

        // 15! fits in 48 bits
        req0 = 1'b1; n0 = 4'd15;
        accept("n15", 1'b1, 1'b0, 1'b1);
        wait_done("n15", 15, 64'd1307674368000, 1'b0);

        // operand changed after grant is ignored
        req0 = 1'b1; n0 = 4'd6;
        accept("n6", 1'b1, 1'b0, 1'b1);
        n0 = 4'd2;
        wait_done("n6", 6, 64'd720, 1'b0);

        // tie after requester 0 served: requester 1 wins
        req0 = 1'b1; req1 = 1'b1; n0 = 4'd2; n1 = 4'd3;
        accept("tie", 1'b0, 1'b1, 1'b1);
        wait_done("tie", 3, 64'd6, 1'b1);

        // abort mid-job by reset
        req0 = 1'b1; n0 = 4'd10;
        accept("abort", 1'b1, 1'b0, 1'b1);
        repeat (3) begin
            tick();
            chk("abort no early done", 64'(done), 64'd0);
        end
        rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort Z", 64'(Z), 64'd0);
        chk("abort owner", 64'(owner), 64'd0);
        chk("abort gnt", 64'(gnt0 | gnt1), 64'd0);
        repeat (2) begin
            tick();
            chk("abort done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        repeat (8) begin
            tick();
            chk("after abort done", 64'(done), 64'd0);
        end
        req0 = 1'b1; n0 = 4'd4;
        accept("post", 1'b1, 1'b0, 1'b1);
        wait_done("post", 4, 64'd24, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fact_sched.md
FACT_SCHED -- requirements
Module: fact_sched

Interface
REQ-001 SHALL have parameter NW, default 4, operand width of N.
REQ-002 SHALL have parameter ZW, default 48, result width of Z.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req0  input  1  requester 0 asks for a factorial.
REQ-006 SHALL have port n0  input  NW  requester 0 operand.
REQ-007 SHALL have port req1  input  1  requester 1 asks for a factorial.
REQ-008 SHALL have port n1  input  NW  requester 1 operand.
REQ-009 SHALL have port gnt0  output  1  one-cycle pulse; requester 0 accepted, n0 sampled.
REQ-010 SHALL have port gnt1  output  1  one-cycle pulse; requester 1 accepted, n1 sampled.
REQ-011 SHALL have port busy  output  1  high while a job is in progress (state MUL).
REQ-012 SHALL have port done  output  1  one-cycle pulse; Z and owner valid.
REQ-013 SHALL have port Z  output  ZW  last result, held until the next done.
REQ-014 SHALL have port owner  output  1  requester index of the job that produced Z.

Function
REQ-015 SHALL implement FSM states IDLE and MUL; encoding comes from the package.
REQ-016 In IDLE, with any req high, SHALL at the next edge: grant one requester, latch its N into nreg, load acc=1 and cnt=2, latch owner, and enter MUL.
REQ-017 Arbitration SHALL be round-robin: when only one req is high, that requester wins; when both are high, the requester not served last wins; after reset, requester 0 is preferred.
REQ-018 gnt0/gnt1 SHALL be registered and high exactly during the cycle after the accept edge; they are never high simultaneously.
REQ-019 Requests SHALL be level-sensitive; a req dropped before its grant is not served; a req still high after its grant is treated as a new job.
REQ-020 In MUL, if cnt<=nreg, SHALL set acc<=acc*cnt truncated to ZW bits and cnt<=cnt+1 at each edge.
REQ-021 In MUL, if cnt>nreg, SHALL set Z<=acc, done<=1 and state<=IDLE at the next edge.
REQ-022 done SHALL assert exactly max(N,1) edges after the accept edge (N=0 and N=1 give Z=1 after 1 cycle).
REQ-023 cnt SHALL be NW+1 bits so that cnt=16 never wraps for N=15.
REQ-024 No request SHALL be accepted during MUL; the earliest new accept is the edge after the done edge.
REQ-025 n0/n1 changes after the grant SHALL NOT affect the running job.

Reset
REQ-026 While rst_n=0, SHALL force state=IDLE, gnt0=gnt1=0, busy=0, done=0, Z=0, owner=0, rr pointer=requester 1 last served, acc=1, cnt=2, nreg=0.
REQ-027 Reset asserted mid-MUL SHALL abort the job immediately, with no done pulse; after release, operation resumes from IDLE on the next edge.

Structure
REQ-028 Package fact_pkg SHALL hold NW, ZW and the state enumeration.
REQ-029 Arbitration SHALL be a sub-module, rr_arb2 (inputs: req0, req1, last; outputs: a one-hot grant), instantiated once.
REQ-030 The multiplier SHALL be a single shared ZW x (NW+1) instance; there is no combinational path from inputs to outputs.

Verification
REQ-031 req0=1, n0=5 -> gnt0 pulse; done 5 cycles after the accept edge; Z=120, owner=0.
REQ-032 req1=1, n1=0, then n1=1 -> each job completes 1 cycle after accept with Z=1 and owner=1.
REQ-033 req0 and req1 both high from reset, n0=3, n1=4 -> gnt0 first, Z=6 (owner 0), then gnt1, Z=24 (owner 1); with both held high, grants alternate 0,1,0.
REQ-034 n0=15 -> Z=1307674368000 after 15 cycles; no truncation occurs.
REQ-035 Start n0=10, then pull rst_n low 4 cycles after accept -> no done pulse; all outputs equal their reset values; a subsequent n0=4 job gives Z=24.
REQ-036 Change n0 from 6 to 2 on the cycle after gnt0 -> Z=720 (the latched operand is used).
